// File: rtl/muller_c_hs_driver.sv
// Four-phase handshake driver for an asynchronous Muller C-element: skewed a/b
// edges, 2-flop readback of c, hold-property check, timeout and handshake count.
module muller_c_hs_driver #(
   parameter int unsigned SKEW_W = 4,
   parameter int unsigned TMO_W  = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              en_i,
   input  logic [SKEW_W-1:0] skew_i,
   input  logic [TMO_W-1:0]  timeout_i,
   input  logic              c_i,
   output logic              a_o,
   output logic              b_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic [CNT_W-1:0]  cycles_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RISE_A,
      S_WAIT_HI,
      S_FALL_A,
      S_WAIT_LO,
      S_ERR
   } state_t;

   localparam logic [1:0]       ERR_TMO  = 2'b01;
   localparam logic [1:0]       ERR_HOLD = 2'b10;
   localparam logic [TMO_W-1:0] TMR_MAX  = '1;

   state_t            state;
   logic              s1;
   logic              c_sync;
   logic [SKEW_W-1:0] skew_cnt;
   logic [TMO_W-1:0]  timer;
   logic              tmo_hit;

   assign tmo_hit = (timeout_i != '0) && (timer == timeout_i);

   // c_i is asynchronous; the FSM only ever looks at c_sync
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= S_IDLE;
         s1         <= 1'b0;
         c_sync     <= 1'b0;
         skew_cnt   <= '0;
         timer      <= '0;
         a_o        <= 1'b0;
         b_o        <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         err_code_o <= 2'b00;
         cycles_o   <= '0;
      end else begin
         s1     <= c_i;
         c_sync <= s1;
         done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (en_i) begin
                  a_o      <= 1'b1;
                  skew_cnt <= skew_i;
                  busy_o   <= 1'b1;
                  state    <= S_RISE_A;
               end
            end
            S_RISE_A: begin
               if (c_sync) begin
                  a_o        <= 1'b0;
                  b_o        <= 1'b0;
                  busy_o     <= 1'b0;
                  err_o      <= 1'b1;
                  err_code_o <= ERR_HOLD;
                  state      <= S_ERR;
               end else if (skew_cnt == '0) begin
                  b_o   <= 1'b1;
                  timer <= '0;
                  state <= S_WAIT_HI;
               end else begin
                  skew_cnt <= skew_cnt - SKEW_W'(1);
               end
            end
            // c arrival takes priority over a timeout in the same cycle
            S_WAIT_HI: begin
               if (c_sync) begin
                  a_o      <= 1'b0;
                  skew_cnt <= skew_i;
                  state    <= S_FALL_A;
               end else if (tmo_hit) begin
                  a_o        <= 1'b0;
                  b_o        <= 1'b0;
                  busy_o     <= 1'b0;
                  err_o      <= 1'b1;
                  err_code_o <= ERR_TMO;
                  state      <= S_ERR;
               end else if (timer != TMR_MAX) begin
                  timer <= timer + TMO_W'(1);
               end
            end
            S_FALL_A: begin
               if (!c_sync) begin
                  a_o        <= 1'b0;
                  b_o        <= 1'b0;
                  busy_o     <= 1'b0;
                  err_o      <= 1'b1;
                  err_code_o <= ERR_HOLD;
                  state      <= S_ERR;
               end else if (skew_cnt == '0) begin
                  b_o   <= 1'b0;
                  timer <= '0;
                  state <= S_WAIT_LO;
               end else begin
                  skew_cnt <= skew_cnt - SKEW_W'(1);
               end
            end
            S_WAIT_LO: begin
               if (!c_sync) begin
                  done_o   <= 1'b1;
                  cycles_o <= cycles_o + CNT_W'(1);
                  busy_o   <= 1'b0;
                  state    <= S_IDLE;
               end else if (tmo_hit) begin
                  a_o        <= 1'b0;
                  b_o        <= 1'b0;
                  busy_o     <= 1'b0;
                  err_o      <= 1'b1;
                  err_code_o <= ERR_TMO;
                  state      <= S_ERR;
               end else if (timer != TMR_MAX) begin
                  timer <= timer + TMO_W'(1);
               end
            end
            S_ERR: begin
               a_o    <= 1'b0;
               b_o    <= 1'b0;
               busy_o <= 1'b0;
               err_o  <= 1'b1;
            end
            default: begin
               a_o    <= 1'b0;
               b_o    <= 1'b0;
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule
